// File: rtl/multi_header_comparer_pkg.sv
// Shared definitions for the multi-reference header comparer: state
// encoding, default byte width, wildcard byte and reference byte selection.
package comparer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_REJECT  = 2'd3
    } state_t;

    localparam int DEFAULT_B = 8;
    localparam logic [7:0] WILDCARD_BYTE = 8'h3F;

    // Upper bounds for the generic reference-byte selector below.
    localparam int MAX_B        = 32;
    localparam int MAX_REF_BITS = 4096;

    // Byte i of entry k from the packed reference vector. Entry 0 is the
    // leftmost string and byte 0 (first received) is the most significant.
    function automatic logic [MAX_B-1:0] ref_byte(
        input logic [MAX_REF_BITS-1:0] refs,
        input int n,
        input int l,
        input int b,
        input int k,
        input int i
    );
        logic [MAX_REF_BITS-1:0] shifted;
        logic [MAX_B-1:0]        r;
        int                      lsb;
        lsb     = ((n - 1 - k) * l + (l - 1 - i)) * b;
        shifted = refs >> lsb;
        r       = shifted[MAX_B-1:0];
        for (int j = 0; j < MAX_B; j++) begin
            if (j >= b) r[j] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_header_comparer_header_lane.sv
// One reference entry of the header comparer: keeps the entry's alive bit
// and compares the incoming byte against the entry's byte at the current
// position. With MULTI_HEADER_COMPARER_WILDCARD_EN defined, a reference
// byte of '?' matches any data byte.
module header_lane
    import comparer_pkg::*;
#(
    parameter int B = DEFAULT_B,
    parameter int L = 6,
    parameter int N = 4,
    parameter int K = 0,
    parameter logic [N*L*B-1:0] REFS = '0,
    localparam int CW = $clog2(L + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          restart,
    input  logic          step,
    input  logic [B-1:0]  data,
    input  logic [CW-1:0] index,
    output logic          alive,
    output logic          hit
);

    logic [B-1:0] ref_bytes [L];
    logic [B-1:0] cur_ref;
    logic         byte_eq;

    for (genvar i = 0; i < L; i++) begin : g_ref
        assign ref_bytes[i] = B'(ref_byte(MAX_REF_BITS'(REFS), N, L, B, K, i));
    end

    // Reference byte at the current position; positions past the header
    // never produce a hit.
    always_comb begin
        cur_ref = '0;
        for (int i = 0; i < L; i++) begin
            if (index == CW'(i)) cur_ref = ref_bytes[i];
        end
    end

`ifdef MULTI_HEADER_COMPARER_WILDCARD_EN
    assign byte_eq = (cur_ref == B'(WILDCARD_BYTE)) || (data == cur_ref);
`else
    assign byte_eq = (data == cur_ref);
`endif

    assign hit = alive && (index < CW'(L)) && byte_eq;

    // Alive bit: armed by restart, cleared on the first mismatching byte.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            alive <= 1'b0;
        end else if (restart) begin
            alive <= 1'b1;
        end else if (step) begin
            alive <= hit;
        end
    end

endmodule

// File: rtl/multi_header_comparer.sv
// Streaming header comparer: matches received bytes against N reference
// headers in parallel, reporting early reject, full match, the lowest
// matching entry and the live candidate mask.
// Optional wildcard matching is enabled by MULTI_HEADER_COMPARER_WILDCARD_EN.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | after reset, waiting for restart; load ignored
// PENDING  | comparing, one byte per load
// RESOLVE  | full header matched; sticky until restart/reset
// REJECT   | no candidate left; sticky until restart/reset
module multi_header_comparer
    import comparer_pkg::*;
#(
    parameter int B = DEFAULT_B,
    parameter int L = 6,
    parameter int N = 4,
    parameter logic [N*L*B-1:0] REFS = "$GPZDA$GPRMC$GPGGA$GPGSV",
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(L + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          restart,
    input  logic          load,
    input  logic [B-1:0]  data,
    output logic          busy,
    output logic          resolve,
    output logic          reject,
    output logic [IW-1:0] match_index,
    output logic [N-1:0]  match_mask,
    output logic [CW-1:0] byte_count
);

    state_t        state, state_next;
    logic          step;
    logic [N-1:0]  hit_mask;
    logic [IW-1:0] lowest_hit;
    logic [IW-1:0] index_q;
    logic          last_byte;

    assign step      = (state == ST_PENDING) && load && !restart;
    assign last_byte = (byte_count == CW'(L - 1));

    for (genvar k = 0; k < N; k++) begin : g_lane
        header_lane #(
            .B    (B),
            .L    (L),
            .N    (N),
            .K    (k),
            .REFS (REFS)
        ) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .restart (restart),
            .step    (step),
            .data    (data),
            .index   (byte_count),
            .alive   (match_mask[k]),
            .hit     (hit_mask[k])
        );
    end

    // Lowest set bit of the surviving candidates after this byte.
    always_comb begin
        lowest_hit = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit_mask[k]) lowest_hit = IW'(k);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; restart re-arms from any state and drops the byte.
    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = ST_PENDING;
        end else if (step) begin
            if (hit_mask == '0)  state_next = ST_REJECT;
            else if (last_byte)  state_next = ST_RESOLVE;
            else                 state_next = ST_PENDING;
        end
    end

    // Byte counter and matched index; both frozen outside PENDING.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byte_count <= '0;
            index_q    <= '0;
        end else if (restart) begin
            byte_count <= '0;
            index_q    <= '0;
        end else if (step) begin
            byte_count <= byte_count + CW'(1);
            if (last_byte && hit_mask != '0) index_q <= lowest_hit;
        end
    end

    // Outputs decoded from state.
    always_comb begin
        busy        = (state == ST_PENDING);
        resolve     = (state == ST_RESOLVE);
        reject      = (state == ST_REJECT);
        match_index = (state == ST_RESOLVE) ? index_q : '0;
    end

endmodule

// File: tb/tb_multi_header_comparer.sv
module tb_multi_header_comparer;

    localparam int B = 8;
    localparam int L = 6;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         restart;
    logic         load;
    logic [B-1:0] data;

    logic         busy, resolve, reject;
    logic [1:0]   match_index;
    logic [N-1:0] match_mask;
    logic [2:0]   byte_count;

    logic         wc_busy, wc_resolve, wc_reject;
    logic [1:0]   wc_match_index;
    logic [N-1:0] wc_match_mask;
    logic [2:0]   wc_byte_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multi_header_comparer #(.B(B), .L(L), .N(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .restart     (restart),
        .load        (load),
        .data        (data),
        .busy        (busy),
        .resolve     (resolve),
        .reject      (reject),
        .match_index (match_index),
        .match_mask  (match_mask),
        .byte_count  (byte_count)
    );

    multi_header_comparer #(.B(B), .L(L), .N(N),
                            .REFS("$G?ZDA$GPRMC$GPGGA$GPGSV")) dut_wc (
        .clock       (clock),
        .reset_n     (reset_n),
        .restart     (restart),
        .load        (load),
        .data        (data),
        .busy        (wc_busy),
        .resolve     (wc_resolve),
        .reject      (wc_reject),
        .match_index (wc_match_index),
        .match_mask  (wc_match_mask),
        .byte_count  (wc_byte_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load = 1'b1;
        data = b;
        tick();
        load = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all(input string tag, input logic bz, input logic rs, input logic rj,
                             input logic [1:0] ix, input logic [3:0] mk, input logic [2:0] bc);
        check({tag, ".busy"},    busy,        bz);
        check({tag, ".resolve"}, resolve,     rs);
        check({tag, ".reject"},  reject,      rj);
        check({tag, ".index"},   match_index, ix);
        check({tag, ".mask"},    match_mask,  mk);
        check({tag, ".count"},   byte_count,  bc);
    endtask

    initial begin
        reset_n = 1'b0;
        restart = 1'b0;
        load    = 1'b0;
        data    = '0;
        gap(2);
        check_all("reset", 0, 0, 0, 2'd0, 4'b0000, 3'd0);
        reset_n = 1'b1;

        // Load while IDLE is ignored.
        send_byte("$");
        check_all("idle_load", 0, 0, 0, 2'd0, 4'b0000, 3'd0);

        // Full match on entry 1.
        do_restart();
        check_all("rmc_start", 1, 0, 0, 2'd0, 4'b1111, 3'd0);
        send_str("$GP");
        check_all("rmc_gp", 1, 0, 0, 2'd0, 4'b1111, 3'd3);
        send_str("R");
        check("rmc_r.mask", match_mask, 4'b0010);
        send_str("M");
        check("rmc_m.resolve", resolve, 1'b0);
        send_str("C");
        check_all("rmc_done", 0, 1, 0, 2'd1, 4'b0010, 3'd6);
        send_byte("X");
        check_all("rmc_sticky", 0, 1, 0, 2'd1, 4'b0010, 3'd6);

        // Early reject after 4 bytes.
        do_restart();
        check_all("rej_start", 1, 0, 0, 2'd0, 4'b1111, 3'd0);
        send_str("$GP");
        check("rej_gp.mask", match_mask, 4'b1111);
        send_str("X");
        check_all("rej_x", 0, 0, 1, 2'd0, 4'b0000, 3'd4);
        send_byte("S");
        check_all("rej_sticky", 0, 0, 1, 2'd0, 4'b0000, 3'd4);

        // Narrowing with load gaps, resolves on entry 3.
        do_restart();
        send_str("$GPG");
        check_all("gsv_g", 1, 0, 0, 2'd0, 4'b1100, 3'd4);
        gap(3);
        check_all("gsv_gap1", 1, 0, 0, 2'd0, 4'b1100, 3'd4);
        send_str("S");
        check_all("gsv_s", 1, 0, 0, 2'd0, 4'b1000, 3'd5);
        gap(3);
        check_all("gsv_gap2", 1, 0, 0, 2'd0, 4'b1000, 3'd5);
        send_str("V");
        check_all("gsv_done", 0, 1, 0, 2'd3, 4'b1000, 3'd6);

        // Restart with load mid-header: byte dropped.
        do_restart();
        send_str("$GP");
        restart = 1'b1;
        send_byte("Z");
        restart = 1'b0;
        check_all("mid_restart", 1, 0, 0, 2'd0, 4'b1111, 3'd0);
        send_str("$GPZDA");
        check_all("zda_done", 0, 1, 0, 2'd0, 4'b0001, 3'd6);

        // Reset while pending.
        do_restart();
        send_str("$GP");
        check("pre_reset.count", byte_count, 3'd3);
        reset_n = 1'b0;
        tick();
        check_all("mid_reset", 0, 0, 0, 2'd0, 4'b0000, 3'd0);
        reset_n = 1'b1;
        send_byte("$");
        check_all("post_reset_idle", 0, 0, 0, 2'd0, 4'b0000, 3'd0);

        // Wildcard reference "$G?ZDA" against "$GNZDA".
        do_restart();
        send_str("$GN");
        check("gn.main_reject", reject, 1'b1);
        check("gn.main_count", byte_count, 3'd3);
`ifdef MULTI_HEADER_COMPARER_WILDCARD_EN
        check("wc_n.busy", wc_busy, 1'b1);
        check("wc_n.mask", wc_match_mask, 4'b0001);
        send_str("ZDA");
        check("wc_done.resolve", wc_resolve, 1'b1);
        check("wc_done.index", wc_match_index, 2'd0);
        check("wc_done.mask", wc_match_mask, 4'b0001);
`else
        check("wc_n.reject", wc_reject, 1'b1);
        check("wc_n.count", wc_byte_count, 3'd3);
        send_str("ZDA");
        check("wc_sticky.reject", wc_reject, 1'b1);
        check("wc_sticky.resolve", wc_resolve, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
